// File: rtl/str_pkg.sv
// str_pkg: shared definitions for the ASCII string parsers.
// ASCII character codes, the frame width in characters, the parser
// state encoding and the character classes produced by str_char_class.
package str_pkg;

  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_1   = 8'h31;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;

  // Characters in a fixed-width frame; the last one ends the frame implicitly.
  localparam int STR_CHARS = 16;
  // Counter width able to hold 0..STR_CHARS.
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    DRAIN  = 2'd2,
    EMIT   = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    DIGIT0 = 3'd0,
    DIGIT1 = 3'd1,
    PAD    = 3'd2,
    TERM   = 3'd3,
    BAD    = 3'd4
  } cls_e;

  function automatic logic is_digit(input cls_e c);
    return (c == DIGIT0) || (c == DIGIT1);
  endfunction

endpackage

// File: rtl/str2d_b_if.sv
// str2d_b_if: character input handshake plus parsed-value outputs.
// master = character source / value consumer, slave = the parser.
interface str2d_b_if #(
  parameter int LEN = 16
) ();

  logic           ch_valid;
  logic [7:0]     ch_data;
  logic           ch_ready;
  logic [LEN-1:0] d;
  logic           d_valid;
  logic           err;

  modport master (
    output ch_valid, ch_data,
    input  ch_ready, d, d_valid, err
  );

  modport slave (
    input  ch_valid, ch_data,
    output ch_ready, d, d_valid, err
  );

endinterface

// File: rtl/str_char_class.sv
// str_char_class: purely combinational ASCII -> character-class decode.
// Shared by the string parsers so every parser agrees on what a digit,
// pad, terminator or illegal character is.
module str_char_class
  import str_pkg::*;
(
  input  logic [7:0] i_ch,
  output cls_e       o_cls
);

  // Classify the incoming character.
  always_comb begin
    case (i_ch)
      CH_0:         o_cls = DIGIT0;
      CH_1:         o_cls = DIGIT1;
      CH_DOT:       o_cls = PAD;
      CH_CR, CH_LF: o_cls = TERM;
      default:      o_cls = BAD;
    endcase
  end

endmodule

// File: rtl/str2d_b.sv
// str2d_b: ASCII '0'/'1' string to binary parser.
// Frames are up to 16 characters, leading '.' padding allowed, ended by
// CR/LF or by the 16th character. Digits shift in MSB first so a short
// frame ends up right-aligned. A committed frame pulses d_valid (with d
// updated), a rejected one pulses err, each in the cycle after the
// frame-ending transfer; that cycle (EMIT) refuses input.
// Optional feature: define STR2D_ERRCNT_EN to add err_cnt, a saturating
// 8-bit count of err pulses.
module str2d_b
  import str_pkg::*;
#(
  parameter int LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  str2d_b_if.slave   bus
`ifdef STR2D_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  state_e           r_state;
  state_e           w_state_nxt;
  cls_e             w_cls;
  logic             w_xfer;
  logic             w_bit;
  logic             w_last;
  logic             w_full;
  logic             w_bad_end;
  logic             w_commit_ok;
  logic             w_commit_err;
  logic [LEN-1:0]   r_shift;
  logic [LEN-1:0]   w_shift_nxt;
  logic [CNT_W-1:0] r_ccnt;
  logic [CNT_W-1:0] w_ccnt_nxt;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] w_dcnt_nxt;
  logic [LEN-1:0]   r_d;
  logic             r_dvalid;
  logic             r_err;
  logic             r_ready;

  str_char_class u_cls (
    .i_ch  (bus.ch_data),
    .o_cls (w_cls)
  );

  assign w_xfer = bus.ch_valid & r_ready;
  assign w_bit  = (w_cls == DIGIT1);
  // The character being accepted now is the last one of a fixed-width frame.
  assign w_last = (r_ccnt == CNT_W'(STR_CHARS - 1));
  // No room left for another digit.
  assign w_full = (r_dcnt == CNT_W'(LEN));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; w_bad_end marks a frame that ends in rejection.
  always_comb begin
    w_state_nxt = r_state;
    w_bad_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          case (w_cls)
            TERM: begin
              // A bare terminator is an empty frame; after pads only it is an error.
              if (r_ccnt != CNT_W'(0)) begin
                w_state_nxt = EMIT;
                w_bad_end   = 1'b1;
              end else begin
                w_state_nxt = IDLE;
              end
            end
            PAD: begin
              if (w_last) begin
                w_state_nxt = EMIT;
                w_bad_end   = 1'b1;
              end else begin
                w_state_nxt = IDLE;
              end
            end
            DIGIT0, DIGIT1: begin
              w_state_nxt = w_last ? EMIT : DIGITS;
            end
            default: begin
              w_bad_end   = 1'b1;
              w_state_nxt = w_last ? EMIT : DRAIN;
            end
          endcase
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DIGITS: begin
        if (w_xfer) begin
          case (w_cls)
            TERM: begin
              w_state_nxt = EMIT;
            end
            DIGIT0, DIGIT1: begin
              w_bad_end   = w_full;
              if (w_last) begin
                w_state_nxt = EMIT;
              end else begin
                w_state_nxt = w_full ? DRAIN : DIGITS;
              end
            end
            default: begin
              w_bad_end   = 1'b1;
              w_state_nxt = w_last ? EMIT : DRAIN;
            end
          endcase
        end else begin
          w_state_nxt = DIGITS;
        end
      end
      DRAIN: begin
        w_bad_end = 1'b1;
        if (w_xfer && ((w_cls == TERM) || w_last)) begin
          w_state_nxt = EMIT;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      EMIT: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath next values and commit strobes.
  always_comb begin
    w_shift_nxt  = r_shift;
    w_ccnt_nxt   = r_ccnt;
    w_dcnt_nxt   = r_dcnt;
    w_commit_ok  = 1'b0;
    w_commit_err = 1'b0;
    if (r_state == EMIT) begin
      w_shift_nxt = '0;
      w_ccnt_nxt  = CNT_W'(0);
      w_dcnt_nxt  = CNT_W'(0);
    end else if (w_xfer && (w_cls != TERM)) begin
      w_ccnt_nxt = r_ccnt + CNT_W'(1);
      // Only digits that belong to the value are shifted; overflow goes to DRAIN.
      if (is_digit(w_cls) && ((r_state == IDLE) || (r_state == DIGITS)) && !w_full) begin
        w_shift_nxt = (r_shift << 1) | LEN'(w_bit);
        w_dcnt_nxt  = r_dcnt + CNT_W'(1);
      end else begin
        w_shift_nxt = r_shift;
        w_dcnt_nxt  = r_dcnt;
      end
    end else begin
      w_shift_nxt = r_shift;
    end
    if ((r_state != EMIT) && (w_state_nxt == EMIT)) begin
      w_commit_ok  = ~w_bad_end;
      w_commit_err = w_bad_end;
    end else begin
      w_commit_ok  = 1'b0;
      w_commit_err = 1'b0;
    end
  end

  // Shift register and character/digit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_ccnt  <= CNT_W'(0);
      r_dcnt  <= CNT_W'(0);
    end else begin
      r_shift <= w_shift_nxt;
      r_ccnt  <= w_ccnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  // Registered outputs: value, result pulses and input ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d      <= '0;
      r_dvalid <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      if (w_commit_ok) begin
        r_d <= w_shift_nxt;
      end
      r_dvalid <= w_commit_ok;
      r_err    <= w_commit_err;
      r_ready  <= (w_state_nxt != EMIT);
    end
  end

  assign bus.d        = r_d;
  assign bus.d_valid  = r_dvalid;
  assign bus.err      = r_err;
  assign bus.ch_ready = r_ready;

`ifdef STR2D_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of rejected frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_commit_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_str2d_b.sv
// tb_str2d_b: three parsers (LEN 16, 8, 4) share one character stream;
// a frame-level reference model predicts every output each cycle, a
// table of frames checks the documented cases, then random traffic runs.
module tb_str2d_b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;

  always #5 clk = ~clk;

  str2d_b_if #(.LEN(16)) if16 ();
  str2d_b_if #(.LEN(8))  if8 ();
  str2d_b_if #(.LEN(4))  if4 ();

  assign if16.ch_valid = s_valid;
  assign if16.ch_data  = s_data;
  assign if8.ch_valid  = s_valid;
  assign if8.ch_data   = s_data;
  assign if4.ch_valid  = s_valid;
  assign if4.ch_data   = s_data;

`ifdef STR2D_ERRCNT_EN
  logic [7:0] ec [3];
`endif

  str2d_b #(.LEN(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16)
`ifdef STR2D_ERRCNT_EN
    , .err_cnt(ec[0])
`endif
  );
  str2d_b #(.LEN(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8)
`ifdef STR2D_ERRCNT_EN
    , .err_cnt(ec[1])
`endif
  );
  str2d_b #(.LEN(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4)
`ifdef STR2D_ERRCNT_EN
    , .err_cnt(ec[2])
`endif
  );

  logic [15:0] dd  [3];
  logic        dv  [3];
  logic        de  [3];
  logic        rdy [3];

  assign dd[0]  = if16.d;
  assign dd[1]  = {8'h00, if8.d};
  assign dd[2]  = {12'h000, if4.d};
  assign dv[0]  = if16.d_valid;
  assign dv[1]  = if8.d_valid;
  assign dv[2]  = if4.d_valid;
  assign de[0]  = if16.err;
  assign de[1]  = if8.err;
  assign de[2]  = if4.err;
  assign rdy[0] = if16.ch_ready;
  assign rdy[1] = if8.ch_ready;
  assign rdy[2] = if4.ch_ready;

  int LENS [3] = '{16, 8, 4};

  // Reference model state
  byte unsigned frm[$];
  logic [15:0]  exp_d [3];
  int           exp_ecnt [3];
  logic         exp_rdy;
  int           seen_ev [3];
  logic [15:0]  seen_d [3];
  int           pulse_cnt;
  int           errors = 0;
  int           checks = 0;

  typedef struct {
    string       txt;   // '|' stands for CR, '~' for LF
    int          ev16;  // 0 none, 1 d_valid, 2 err
    int          ev8;
    int          ev4;
    logic [15:0] v16;
    logic [15:0] v8;
    logic [15:0] v4;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Judge a completed frame: optional leading pads, then 1..len binary digits.
  function automatic int eval_frame(input int len, output logic [15:0] val);
    int i = 0;
    int n;
    val = 16'h0000;
    while (i < frm.size() && frm[i] == 8'h2E) i++;
    n = frm.size() - i;
    if (n == 0 || n > len) return 2;
    for (int k = i; k < frm.size(); k++) begin
      if (frm[k] == 8'h30) val = {val[14:0], 1'b0};
      else if (frm[k] == 8'h31) val = {val[14:0], 1'b1};
      else return 2;
    end
    return 1;
  endfunction

  // One clock: drive at negedge, compare every output at the next negedge.
  task automatic cyc(input logic v, input logic [7:0] c, output logic took);
    logic        ended;
    int          ev [3];
    logic [15:0] val;
    s_valid = v;
    s_data  = c;
    took    = v && exp_rdy;
    @(posedge clk);
    @(negedge clk);
    ended = 1'b0;
    for (int k = 0; k < 3; k++) ev[k] = 0;
    if (took) begin
      if (c == 8'h0D || c == 8'h0A) begin
        ended = (frm.size() != 0);
      end else begin
        frm.push_back(c);
        ended = (frm.size() == 16);
      end
      if (ended) begin
        for (int k = 0; k < 3; k++) begin
          ev[k] = eval_frame(LENS[k], val);
          if (ev[k] == 1) exp_d[k] = val;
          if (ev[k] == 2 && exp_ecnt[k] < 255) exp_ecnt[k]++;
        end
        frm.delete();
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d_valid[L%0d]", LENS[k]), {31'd0, dv[k]}, (ev[k] == 1) ? 32'd1 : 32'd0);
      chk($sformatf("err[L%0d]", LENS[k]), {31'd0, de[k]}, (ev[k] == 2) ? 32'd1 : 32'd0);
      chk($sformatf("d[L%0d]", LENS[k]), {16'd0, dd[k]}, {16'd0, exp_d[k]});
      chk($sformatf("ch_ready[L%0d]", LENS[k]), {31'd0, rdy[k]}, ended ? 32'd0 : 32'd1);
`ifdef STR2D_ERRCNT_EN
      chk($sformatf("err_cnt[L%0d]", LENS[k]), {24'd0, ec[k]}, exp_ecnt[k]);
`endif
      if (dv[k]) begin
        seen_ev[k] = 1;
        seen_d[k]  = dd[k];
      end
      if (de[k]) seen_ev[k] = 2;
    end
    if (dv[0]) pulse_cnt++;
    exp_rdy = !ended;
  endtask

  // Offer one character with ch_valid held until it is taken (bounded).
  task automatic send(input logic [7:0] c);
    logic took;
    int   tries = 0;
    do begin
      cyc(1'b1, c, took);
      tries++;
    end while (!took && tries < 4);
    if (!took) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: char %0h not accepted after %0d cycles", c, tries);
    end
  endtask

  task automatic send_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == 8'h7C) c = 8'h0D;
      else if (c == 8'h7E) c = 8'h0A;
      send(c);
    end
  endtask

  // Asynchronous reset from mid-cycle; checks reset values while held.
  task automatic do_reset();
    s_valid = 1'b0;
    s_data  = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready[L%0d]", LENS[k]), {31'd0, rdy[k]}, 32'd0);
      chk($sformatf("rst_dvalid[L%0d]", LENS[k]), {31'd0, dv[k]}, 32'd0);
      chk($sformatf("rst_err[L%0d]", LENS[k]), {31'd0, de[k]}, 32'd0);
      chk($sformatf("rst_d[L%0d]", LENS[k]), {16'd0, dd[k]}, 32'd0);
`ifdef STR2D_ERRCNT_EN
      chk($sformatf("rst_err_cnt[L%0d]", LENS[k]), {24'd0, ec[k]}, 32'd0);
`endif
      exp_d[k]    = 16'h0000;
      exp_ecnt[k] = 0;
    end
    frm.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_rdy = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        took;
    logic [7:0]  c;
    int          r;
    int          evs [3];
    logic [15:0] vs [3];
    int          pc0;

    tbl[0]  = '{"1010000011110001", 1, 2, 2, 16'hA0F1, 16'h0000, 16'h0000};
    tbl[1]  = '{"~",                0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[2]  = '{"........10110011", 1, 1, 2, 16'h00B3, 16'h00B3, 16'h0000};
    tbl[3]  = '{"101|",             1, 1, 1, 16'h0005, 16'h0005, 16'h0005};
    tbl[4]  = '{"10x1~",            2, 2, 2, 16'h0000, 16'h0000, 16'h0000};
    tbl[5]  = '{"10101|",           1, 1, 2, 16'h0015, 16'h0015, 16'h0000};
    tbl[6]  = '{"|",                0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[7]  = '{"...|",             2, 2, 2, 16'h0000, 16'h0000, 16'h0000};
    tbl[8]  = '{"1.1|",             2, 2, 2, 16'h0000, 16'h0000, 16'h0000};
    tbl[9]  = '{"................", 2, 2, 2, 16'h0000, 16'h0000, 16'h0000};
    tbl[10] = '{"11111111|",        1, 1, 2, 16'h00FF, 16'h00FF, 16'h0000};
    tbl[11] = '{"0000|",            1, 1, 1, 16'h0000, 16'h0000, 16'h0000};
    tbl[12] = '{"1111|",            1, 1, 1, 16'h000F, 16'h000F, 16'h000F};
    tbl[13] = '{"x|",               2, 2, 2, 16'h0000, 16'h0000, 16'h0000};
    tbl[14] = '{"1111111111111111", 1, 2, 2, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[15] = '{".1~",              1, 1, 1, 16'h0001, 16'h0001, 16'h0001};

    pulse_cnt = 0;
    exp_rdy   = 1'b0;
    do_reset();

    // Table of frames, characters sent back to back with ch_valid held high
    for (int t = 0; t < 16; t++) begin
      for (int k = 0; k < 3; k++) seen_ev[k] = 0;
      send_str(tbl[t].txt);
      evs[0] = tbl[t].ev16; evs[1] = tbl[t].ev8; evs[2] = tbl[t].ev4;
      vs[0]  = tbl[t].v16;  vs[1]  = tbl[t].v8;  vs[2]  = tbl[t].v4;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("tbl%0d_event[L%0d]", t, LENS[k]), seen_ev[k], evs[k]);
        if (evs[k] == 1)
          chk($sformatf("tbl%0d_value[L%0d]", t, LENS[k]), {16'd0, seen_d[k]}, {16'd0, vs[k]});
      end
    end

    // Reset in the middle of a frame, then a fresh short frame
    send_str("110");
    do_reset();
    pc0 = pulse_cnt;
    for (int k = 0; k < 3; k++) seen_ev[k] = 0;
    send_str("1|");
    cyc(1'b0, 8'h00, took);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_rst_event[L%0d]", LENS[k]), seen_ev[k], 1);
      chk($sformatf("post_rst_value[L%0d]", LENS[k]), {16'd0, seen_d[k]}, 32'd1);
    end
    chk("post_rst_pulses", pulse_cnt - pc0, 1);

    // Random traffic with idle gaps and junk data while ch_valid is low
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 19);
      if (r <= 6) c = 8'h30;
      else if (r <= 13) c = 8'h31;
      else if (r <= 15) c = 8'h2E;
      else if (r == 16) c = 8'h0D;
      else if (r == 17) c = 8'h0A;
      else if (r == 18) c = 8'h78;
      else c = 8'($urandom_range(0, 255));
      cyc($urandom_range(0, 3) != 0, c, took);
    end

`ifdef STR2D_ERRCNT_EN
    do_reset();
    for (int i = 0; i < 300; i++) send_str("x|");
    cyc(1'b0, 8'h00, took);
    for (int k = 0; k < 3; k++)
      chk($sformatf("err_cnt_sat[L%0d]", LENS[k]), {24'd0, ec[k]}, 32'd255);
    do_reset();
    for (int k = 0; k < 3; k++)
      chk($sformatf("err_cnt_clr[L%0d]", LENS[k]), {24'd0, ec[k]}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
